// File: rtl/dcache_wt.sv
// Direct-mapped write-through data cache between the MEM stage and mem_ctrl.
// One outstanding request; loads hit in one cycle, misses/stores go through mem_ctrl.
module dcache_wt #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    INDEX_BITS    = 6,
    parameter logic [ADDR_WIDTH-1:0] UNCACHED_BASE = 32'h0003_0000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  req_valid_in,
    input  logic                  req_we_in,
    input  logic [1:0]            req_len_in,
    input  logic                  req_signed_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [31:0]           req_wdata_in,
    input  logic                  invalidate_in,
    output logic                  resp_done_out,
    output logic [31:0]           resp_rdata_out,
    output logic                  stall_out,
    output logic                  mc_read_req_out,
    output logic                  mc_write_req_out,
    output logic [ADDR_WIDTH-1:0] mc_addr_out,
    output logic [31:0]           mc_wdata_out,
    output logic [2:0]            mc_len_out,
    input  logic [1:0]            mc_busy_in,
    input  logic                  mc_done_in,
    input  logic [31:0]           mc_rdata_in,
    output logic [31:0]           hit_cnt_out,
    output logic [31:0]           miss_cnt_out
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_MISS, S_STORE, S_DONE} state_t;

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] len, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (len)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replicate right-aligned store data across the word, then keep only the written lanes.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] len);
        logic [31:0] rep;
        logic [3:0]  mask;
        logic [31:0] r;
        case (len)
            2'd0: begin
                rep  = {4{wd[7:0]}};
                mask = 4'b0001 << off;
            end
            2'd1: begin
                rep  = {2{wd[15:0]}};
                mask = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                rep  = wd;
                mask = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = mask[i] ? rep[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_len;
    logic                  r_signed;
    logic [31:0]           r_wdata;
    logic                  r_uc;
    logic                  r_done;
    logic [31:0]           r_rdata;
    logic                  r_mc_read;
    logic                  r_mc_write;
    logic [ADDR_WIDTH-1:0] r_mc_addr;
    logic [31:0]           r_mc_wdata;
    logic [2:0]            r_mc_len;
    logic [31:0]           r_hit_cnt;
    logic [31:0]           r_miss_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag_arr  [LINES];
    logic [31:0]           r_data_arr [LINES];

    logic [ADDR_WIDTH-1:0] w_addr_al;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [TAG_BITS-1:0]   w_req_tag;
    logic                  w_req_uc;
    logic                  w_req_hit;
    logic [2:0]            w_wlen;
    logic [2:0]            w_rlen;
    logic [INDEX_BITS-1:0] w_cur_idx;
    logic [TAG_BITS-1:0]   w_cur_tag;
    logic                  w_cur_hit;
    logic                  w_line_we;
    logic [31:0]           w_line_data;

    // Request decode: natural alignment, index/tag split, lookup and mem_ctrl lengths.
    always_comb begin
        w_addr_al = req_addr_in;
        case (req_len_in)
            2'd0: begin
                w_wlen = 3'd0;
                w_rlen = 3'd1;
            end
            2'd1: begin
                w_addr_al[0] = 1'b0;
                w_wlen       = 3'd1;
                w_rlen       = 3'd2;
            end
            default: begin
                w_addr_al[1:0] = 2'b00;
                w_wlen         = 3'd3;
                w_rlen         = 3'd4;
            end
        endcase
        w_req_idx = w_addr_al[INDEX_BITS+1:2];
        w_req_tag = w_addr_al[ADDR_WIDTH-1:INDEX_BITS+2];
        w_req_uc  = (w_addr_al >= UNCACHED_BASE);
        w_req_hit = r_valid[w_req_idx] && (r_tag_arr[w_req_idx] == w_req_tag);
    end

    assign w_cur_idx = r_addr[INDEX_BITS+1:2];
    assign w_cur_tag = r_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_cur_hit = r_valid[w_cur_idx] && (r_tag_arr[w_cur_idx] == w_cur_tag);

    // Line write on completion: fill, store-hit merge or full-word allocate; invalidate suppresses it.
    always_comb begin
        w_line_we   = 1'b0;
        w_line_data = mc_rdata_in;
        if (rdy_in && !invalidate_in && mc_done_in && !r_uc) begin
            if (r_state == S_LOAD_MISS && r_mc_read) begin
                w_line_we = 1'b1;
            end else if (r_state == S_STORE && r_mc_write) begin
                if (w_cur_hit) begin
                    w_line_we   = 1'b1;
                    w_line_data = merge(r_data_arr[w_cur_idx], r_wdata, r_addr[1:0], r_len);
                end else if (r_len[1]) begin
                    w_line_we   = 1'b1;
                    w_line_data = r_wdata;
                end else begin
                    w_line_we = 1'b0;
                end
            end else begin
                w_line_we = 1'b0;
            end
        end else begin
            w_line_we = 1'b0;
        end
    end

    // Tag/data arrays carry no reset; validity lives in r_valid.
    always_ff @(posedge clk_in) begin
        if (w_line_we) begin
            r_tag_arr[w_cur_idx]  <= w_cur_tag;
            r_data_arr[w_cur_idx] <= w_line_data;
        end
    end

    // Control FSM, mem_ctrl handshake, response registers, counters and valid bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= 2'd0;
            r_signed   <= 1'b0;
            r_wdata    <= 32'd0;
            r_uc       <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 32'd0;
            r_mc_read  <= 1'b0;
            r_mc_write <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_wdata <= 32'd0;
            r_mc_len   <= 3'd0;
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
            r_valid    <= '0;
        end else if (rdy_in) begin
            if (invalidate_in) begin
                r_valid <= '0;
            end else if (w_line_we) begin
                r_valid[w_cur_idx] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (req_valid_in) begin
                        r_addr   <= w_addr_al;
                        r_len    <= req_len_in;
                        r_signed <= req_signed_in;
                        r_wdata  <= req_wdata_in;
                        r_uc     <= w_req_uc;
                        if (req_we_in) begin
                            r_mc_addr  <= w_addr_al;
                            r_mc_wdata <= req_wdata_in;
                            r_mc_len   <= w_wlen;
                            r_mc_write <= !mc_busy_in[1];
                            r_state    <= S_STORE;
                        end else if (!w_req_uc && w_req_hit) begin
                            r_rdata <= extend(r_data_arr[w_req_idx], w_addr_al[1:0],
                                              req_len_in, req_signed_in);
                            if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            if (!w_req_uc && r_miss_cnt != 32'hFFFF_FFFF) begin
                                r_miss_cnt <= r_miss_cnt + 32'd1;
                            end
                            r_mc_addr <= w_req_uc ? w_addr_al : {w_addr_al[ADDR_WIDTH-1:2], 2'b00};
                            r_mc_len  <= w_req_uc ? w_rlen : 3'd4;
                            r_mc_read <= !mc_busy_in[1];
                            r_state   <= S_LOAD_MISS;
                        end
                    end
                end
                S_LOAD_MISS: begin
                    if (r_mc_read && mc_done_in) begin
                        r_mc_read <= 1'b0;
                        // Uncached reads come back right-aligned from mem_ctrl.
                        r_rdata   <= extend(mc_rdata_in, r_uc ? 2'b00 : r_addr[1:0], r_len, r_signed);
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (!r_mc_read && !mc_busy_in[1]) begin
                        r_mc_read <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (r_mc_write && mc_done_in) begin
                        r_mc_write <= 1'b0;
                        r_rdata    <= 32'd0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (!r_mc_write && !mc_busy_in[1]) begin
                        r_mc_write <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_mc_read  <= 1'b0;
                    r_mc_write <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_done_out    = r_done;
    assign resp_rdata_out   = r_rdata;
    assign stall_out        = req_valid_in && !r_done;
    assign mc_read_req_out  = r_mc_read;
    assign mc_write_req_out = r_mc_write;
    assign mc_addr_out      = r_mc_addr;
    assign mc_wdata_out     = r_mc_wdata;
    assign mc_len_out       = r_mc_len;
    assign hit_cnt_out      = r_hit_cnt;
    assign miss_cnt_out     = r_miss_cnt;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: the bench plays the MEM stage and mem_ctrl,
// with hand-computed expectations for each access.
module tb_dcache_wt;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid_in;
    logic        req_we_in;
    logic [1:0]  req_len_in;
    logic        req_signed_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        invalidate_in;
    logic        resp_done_out;
    logic [31:0] resp_rdata_out;
    logic        stall_out;
    logic        mc_read_req_out;
    logic        mc_write_req_out;
    logic [31:0] mc_addr_out;
    logic [31:0] mc_wdata_out;
    logic [2:0]  mc_len_out;
    logic [1:0]  mc_busy_in;
    logic        mc_done_in;
    logic [31:0] mc_rdata_in;
    logic [31:0] hit_cnt_out;
    logic [31:0] miss_cnt_out;

    int n_vec = 0;
    int n_err = 0;

    dcache_wt dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid_in(req_valid_in), .req_we_in(req_we_in), .req_len_in(req_len_in),
        .req_signed_in(req_signed_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .invalidate_in(invalidate_in), .resp_done_out(resp_done_out),
        .resp_rdata_out(resp_rdata_out), .stall_out(stall_out),
        .mc_read_req_out(mc_read_req_out), .mc_write_req_out(mc_write_req_out),
        .mc_addr_out(mc_addr_out), .mc_wdata_out(mc_wdata_out), .mc_len_out(mc_len_out),
        .mc_busy_in(mc_busy_in), .mc_done_in(mc_done_in), .mc_rdata_in(mc_rdata_in),
        .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One MEM-stage access. mem_ctrl answers one cycle after first seeing the request.
    task automatic access(input string tag, input logic we, input logic [1:0] len,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_mc, input logic [31:0] exp_mc_addr,
                          input logic [2:0] exp_mc_len, input logic [31:0] mc_data,
                          input logic [31:0] exp_rdata, input int busy_cyc, input logic inval);
        int f;
        int d;
        f = -1;
        d = -1;
        @(negedge clk_in);
        req_valid_in  = 1'b1;
        req_we_in     = we;
        req_len_in    = len;
        req_signed_in = sgn;
        req_addr_in   = addr;
        req_wdata_in  = wdata;
        mc_busy_in    = (busy_cyc > 0) ? 2'b10 : 2'b00;
        #1 chk({tag, " stall"}, {31'd0, stall_out}, 32'd1);
        for (int c = 1; c <= 60 && d < 0; c++) begin
            @(negedge clk_in);
            if (c == busy_cyc) mc_busy_in = 2'b00;
            if (mc_done_in) begin
                mc_done_in    = 1'b0;
                invalidate_in = 1'b0;
            end
            if (resp_done_out) begin
                d = c;
            end else if (mc_read_req_out || mc_write_req_out) begin
                if (f < 0) begin
                    f = c;
                    chk({tag, " mc kind"}, {30'd0, mc_write_req_out, mc_read_req_out},
                        we ? 32'd2 : 32'd1);
                    chk({tag, " mc addr"}, mc_addr_out, exp_mc_addr);
                    chk({tag, " mc len"}, {29'd0, mc_len_out}, {29'd0, exp_mc_len});
                    if (we) chk({tag, " mc wdata"}, mc_wdata_out, wdata);
                end else if (c == f + 1) begin
                    chk({tag, " mc addr held"}, mc_addr_out, exp_mc_addr);
                    mc_done_in    = 1'b1;
                    mc_rdata_in   = mc_data;
                    invalidate_in = inval;
                end
            end
        end
        if (exp_mc) begin
            chk({tag, " mc first cycle"}, 32'(f), 32'(busy_cyc + 1));
            chk({tag, " done cycle"}, 32'(d), 32'(f + 2));
        end else begin
            chk({tag, " mc absent"}, 32'(f), 32'hFFFF_FFFF);
            chk({tag, " done cycle"}, 32'(d), 32'd1);
        end
        chk({tag, " rdata"}, resp_rdata_out, exp_rdata);
        chk({tag, " mc dropped"}, {30'd0, mc_write_req_out, mc_read_req_out}, 32'd0);
        chk({tag, " stall low"}, {31'd0, stall_out}, 32'd0);
        req_valid_in = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        req_valid_in  = 1'b0;
        req_we_in     = 1'b0;
        req_len_in    = 2'd0;
        req_signed_in = 1'b0;
        req_addr_in   = 32'd0;
        req_wdata_in  = 32'd0;
        invalidate_in = 1'b0;
        mc_busy_in    = 2'b00;
        mc_done_in    = 1'b0;
        mc_rdata_in   = 32'd0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        chk("reset done", {31'd0, resp_done_out}, 32'd0);
        chk("reset rdata", resp_rdata_out, 32'd0);
        chk("reset mc req", {30'd0, mc_write_req_out, mc_read_req_out}, 32'd0);
        chk("reset hit", hit_cnt_out, 32'd0);
        chk("reset miss", miss_cnt_out, 32'd0);

        access("LW 100 miss", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b1, 32'h100, 3'd4,
               32'h8899_AABB, 32'h8899_AABB, 0, 1'b0);
        chk("miss after fill", miss_cnt_out, 32'd1);
        access("LW 100 hit", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'h8899_AABB, 0, 1'b0);
        chk("hit after LW", hit_cnt_out, 32'd1);
        access("LB 103", 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'hFFFF_FF88, 0, 1'b0);
        access("LBU 102", 1'b0, 2'd0, 1'b0, 32'h102, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'h0000_0099, 0, 1'b0);
        access("LH 100", 1'b0, 2'd1, 1'b1, 32'h100, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'hFFFF_AABB, 0, 1'b0);
        access("SB 101", 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_0011, 1'b1, 32'h101, 3'd0,
               32'd0, 32'd0, 0, 1'b0);
        access("LW 100 merged", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'h8899_11BB, 0, 1'b0);
        access("SH 200", 1'b1, 2'd1, 1'b0, 32'h200, 32'h0000_1234, 1'b1, 32'h200, 3'd1,
               32'd0, 32'd0, 0, 1'b0);
        access("LW 200 miss", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1, 32'h200, 3'd4,
               32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1'b0);
        access("SW 300", 1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, 1'b1, 32'h300, 3'd3,
               32'd0, 32'd0, 0, 1'b0);
        access("LW 300 hit", 1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        access("LH 302 hit", 1'b0, 2'd1, 1'b1, 32'h303, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'hFFFF_DEAD, 0, 1'b0);
        access("LBU 30000", 1'b0, 2'd0, 1'b0, 32'h3_0000, 32'd0, 1'b1, 32'h3_0000, 3'd1,
               32'h1234_56A5, 32'h0000_00A5, 0, 1'b0);
        access("LB 30000 again", 1'b0, 2'd0, 1'b1, 32'h3_0000, 32'd0, 1'b1, 32'h3_0000, 3'd1,
               32'h0000_00F0, 32'hFFFF_FFF0, 0, 1'b0);
        chk("hit after uncached", hit_cnt_out, 32'd7);
        chk("miss after uncached", miss_cnt_out, 32'd2);
        access("LW 400 inval fill", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 1'b1, 32'h400, 3'd4,
               32'h5566_7788, 32'h5566_7788, 0, 1'b1);
        access("LW 400 busy miss", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 1'b1, 32'h400, 3'd4,
               32'h5566_7788, 32'h5566_7788, 5, 1'b0);
        access("LW 400 hit", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 1'b0, 32'd0, 3'd0,
               32'd0, 32'h5566_7788, 0, 1'b0);
        chk("final hit", hit_cnt_out, 32'd8);
        chk("final miss", miss_cnt_out, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
